// File: rtl/interboard_pkg.sv
// Shared definitions for the board-to-board message link: message field
// layout, beat arithmetic, FSM state encodings and ctrl-field pack/unpack.
package interboard_pkg;

  localparam int MSG_W        = 22;

  localparam int SEL_LEN_LSB  = 0;
  localparam int SEL_LEN_W    = 3;
  localparam int CARD_LSB     = 3;
  localparam int CARD_W       = 6;
  localparam int MSG_TYPE_LSB = 9;
  localparam int MSG_TYPE_W   = 4;
  localparam int BLOCK_Y_LSB  = 13;
  localparam int BLOCK_Y_W    = 3;
  localparam int BLOCK_X_LSB  = 16;
  localparam int BLOCK_X_W    = 5;
  localparam int MOVE_DIR_LSB = 21;
  localparam int MOVE_DIR_W   = 1;

  typedef struct packed {
    logic                  move_dir;
    logic [BLOCK_X_W-1:0]  block_x;
    logic [BLOCK_Y_W-1:0]  block_y;
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [CARD_W-1:0]     card;
    logic [SEL_LEN_W-1:0]  sel_len;
  } ctrl_msg_t;

  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_REQ, T_REL} tx_state_t;
  typedef enum logic       {R_IDLE, R_WAIT} rx_state_t;

  // Beats needed for {parity, message}: ceil((mw + 1) / dw).
  function automatic int beat_count(input int mw, input int dw);
    return (mw + dw) / dw;
  endfunction

  function automatic logic [MSG_W-1:0] pack_ctrl(input ctrl_msg_t f);
    logic [MSG_W-1:0] m;
    m = '0;
    m[MOVE_DIR_LSB +: MOVE_DIR_W] = f.move_dir;
    m[BLOCK_X_LSB  +: BLOCK_X_W]  = f.block_x;
    m[BLOCK_Y_LSB  +: BLOCK_Y_W]  = f.block_y;
    m[MSG_TYPE_LSB +: MSG_TYPE_W] = f.msg_type;
    m[CARD_LSB     +: CARD_W]     = f.card;
    m[SEL_LEN_LSB  +: SEL_LEN_W]  = f.sel_len;
    return m;
  endfunction

  function automatic ctrl_msg_t unpack_ctrl(input logic [MSG_W-1:0] m);
    ctrl_msg_t f;
    f.move_dir = m[MOVE_DIR_LSB];
    f.block_x  = m[BLOCK_X_LSB  +: BLOCK_X_W];
    f.block_y  = m[BLOCK_Y_LSB  +: BLOCK_Y_W];
    f.msg_type = m[MSG_TYPE_LSB +: MSG_TYPE_W];
    f.card     = m[CARD_LSB     +: CARD_W];
    f.sel_len  = m[SEL_LEN_LSB  +: SEL_LEN_W];
    return f;
  endfunction

endpackage

// File: rtl/interboard_fifo.sv
// Synchronous FIFO with first-word fall-through read; DEPTH is a power of two.
module interboard_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/interboard_link.sv
// Board-to-board message link: even-parity framed messages sent as DW-bit
// beats over a four-phase req/ack handshake, with TX FIFO and timeouts.
module interboard_link
  import interboard_pkg::*;
#(
  parameter int MW         = 22,
  parameter int DW         = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          transmit,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [MW-1:0] tx_data,
  output logic          rx_valid,
  output logic [MW-1:0] rx_data,
  output logic          err_parity,
  output logic          err_timeout,
  output logic          req_out,
  output logic          ack_out,
  input  logic          req_in,
  input  logic          ack_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  input  logic [DW-1:0] bus_in
);
  localparam int BEATS = beat_count(MW, DW);
  localparam int FW    = BEATS * DW;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);
  localparam logic [CW-1:0] TMAX      = CW'(TIMEOUT);

  logic [1:0] req_sync, ack_sync;
  logic       req_s, ack_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], req_in};
      ack_sync <= {ack_sync[0], ack_in};
    end
  end

  assign req_s = req_sync[1];
  assign ack_s = ack_sync[1];

  tx_state_t ts, ts_n;
  rx_state_t rs, rs_n;
  logic [KW-1:0] tbeat, tbeat_n, k;
  logic [CW-1:0] tcnt, rcnt;
  logic          role;

  // Role only follows transmit when neither side is mid-message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         role <= 1'b0;
    else if (ts == T_IDLE && rs == R_IDLE && k == '0) role <= transmit;
  end

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [MW-1:0] fifo_head;

  assign fifo_push = tx_valid && tx_ready;
  assign tx_ready  = !fifo_full;

  interboard_fifo #(.WIDTH(MW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  logic [BEATS-1:0][DW-1:0] tx_frame;
  assign tx_frame = FW'({^tx_frame_src(fifo_head), fifo_head});

  function automatic logic [MW-1:0] tx_frame_src(input logic [MW-1:0] m);
    return m;
  endfunction

  logic t_abort;

  always_comb begin
    ts_n     = ts;
    tbeat_n  = tbeat;
    fifo_pop = 1'b0;
    t_abort  = 1'b0;
    unique case (ts)
      // A push into an empty FIFO starts the frame on the very next cycle.
      T_IDLE:  if (role && (!fifo_empty || fifo_push)) begin
                 ts_n    = T_SETUP;
                 tbeat_n = '0;
               end
      T_SETUP: ts_n = T_REQ;
      T_REQ:   if (ack_s)              ts_n    = T_REL;
               else if (tcnt == TMAX)  t_abort = 1'b1;
      T_REL:   if (!ack_s) begin
                 if (tbeat == LAST_BEAT) begin
                   fifo_pop = 1'b1;
                   ts_n     = T_IDLE;
                 end else begin
                   tbeat_n = tbeat + 1'b1;
                   ts_n    = T_SETUP;
                 end
               end else if (tcnt == TMAX) begin
                 t_abort = 1'b1;
               end
    endcase
    if (t_abort) begin
      ts_n     = T_IDLE;
      fifo_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts    <= T_IDLE;
      tbeat <= '0;
      tcnt  <= '0;
    end else begin
      ts    <= ts_n;
      tbeat <= tbeat_n;
      if (ts_n != ts)        tcnt <= '0;
      else if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
    end
  end

  assign bus_oe  = (ts != T_IDLE);
  assign req_out = (ts == T_REQ);
  assign bus_out = bus_oe ? tx_frame[tbeat] : '0;

  logic [BEATS-1:0][DW-1:0] rx_buf;
  logic r_capture, r_done, r_abort;

  always_comb begin
    rs_n      = rs;
    r_capture = 1'b0;
    r_done    = 1'b0;
    r_abort   = 1'b0;
    unique case (rs)
      R_IDLE: if (!role && ts == T_IDLE && req_s) begin
                rs_n      = R_WAIT;
                r_capture = 1'b1;
              end else if (k != '0 && rcnt == TMAX) begin
                r_abort = 1'b1;
              end
      R_WAIT: if (!req_s) begin
                rs_n   = R_IDLE;
                r_done = 1'b1;
              end else if (rcnt == TMAX) begin
                rs_n    = R_IDLE;
                r_abort = 1'b1;
              end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs   <= R_IDLE;
      rcnt <= '0;
    end else begin
      rs <= rs_n;
      if (rs_n != rs)        rcnt <= '0;
      else if (rcnt != TMAX) rcnt <= rcnt + 1'b1;
    end
  end

  assign ack_out = (rs == R_WAIT);

  // Parity covers the whole frame; the zero padding cannot upset a good frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k           <= '0;
      rx_buf      <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= t_abort || r_abort;
      if (r_capture) rx_buf[k] <= bus_in;
      if (r_abort) begin
        k <= '0;
      end else if (r_done) begin
        if (k == LAST_BEAT) begin
          k <= '0;
          if (^rx_buf == 1'b0) begin
            rx_data  <= MW'(rx_buf);
            rx_valid <= 1'b1;
          end else begin
            err_parity <= 1'b1;
          end
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_interboard_link.sv
// Two cross-wired link instances (A transmits, B receives) with a scoreboard
// of messages expected at B, plus fault injection on the wires between them.
module tb_interboard_link;
  import interboard_pkg::*;

  localparam int MW = 22;
  localparam int DW = 6;
  localparam int TO = 1023;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          a_transmit, a_tx_valid, a_tx_ready, a_rx_valid, a_err_parity, a_err_timeout;
  logic          a_req_out, a_ack_out, a_bus_oe, a_ack_in;
  logic [MW-1:0] a_tx_data, a_rx_data;
  logic [DW-1:0] a_bus_out;
  logic          b_transmit, b_tx_valid, b_tx_ready, b_rx_valid, b_err_parity, b_err_timeout;
  logic          b_req_out, b_ack_out, b_bus_oe, b_req_in;
  logic [MW-1:0] b_tx_data, b_rx_data;
  logic [DW-1:0] b_bus_out, b_bus_in;

  logic disc    = 1'b0;
  logic flip_en = 1'b0;
  int   tb_beat = 0;
  logic a_req_d = 1'b0;

  assign b_req_in = disc ? 1'b0 : a_req_out;
  assign a_ack_in = disc ? 1'b0 : b_ack_out;
  assign b_bus_in = a_bus_out ^ ((flip_en && tb_beat == 2) ? DW'(1) : DW'(0));

  interboard_link #(.MW(MW), .DW(DW), .FIFO_DEPTH(4), .TIMEOUT(TO)) u_a (
    .clk(clk), .rst(rst), .transmit(a_transmit), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx_data(a_tx_data), .rx_valid(a_rx_valid), .rx_data(a_rx_data), .err_parity(a_err_parity),
    .err_timeout(a_err_timeout), .req_out(a_req_out), .ack_out(a_ack_out), .req_in(b_req_out),
    .ack_in(a_ack_in), .bus_out(a_bus_out), .bus_oe(a_bus_oe), .bus_in(b_bus_out)
  );

  interboard_link #(.MW(MW), .DW(DW), .FIFO_DEPTH(4), .TIMEOUT(TO)) u_b (
    .clk(clk), .rst(rst), .transmit(b_transmit), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_data(b_tx_data), .rx_valid(b_rx_valid), .rx_data(b_rx_data), .err_parity(b_err_parity),
    .err_timeout(b_err_timeout), .req_out(b_req_out), .ack_out(b_ack_out), .req_in(b_req_in),
    .ack_in(a_ack_out), .bus_out(b_bus_out), .bus_oe(b_bus_oe), .bus_in(b_bus_in)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [MW-1:0] sb[$];
  logic [MW-1:0] last_good = '0;
  int perr_seen = 0;
  int tout_a    = 0;
  int tout_b    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Beat index A is driving, derived from its req_out falls within a frame.
  always @(negedge clk) begin
    if (!a_bus_oe)                   tb_beat <= 0;
    else if (a_req_d && !a_req_out)  tb_beat <= tb_beat + 1;
    a_req_d <= a_req_out;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (b_rx_valid) begin
        if (sb.size() == 0) check("rx_extra", 32'(sb.size()), 1);
        else begin
          logic [MW-1:0] e;
          e = sb.pop_front();
          check("rx_data", 32'(b_rx_data), 32'(e));
          last_good = e;
        end
      end
      if (b_err_parity)  perr_seen++;
      if (a_err_timeout) tout_a++;
      if (b_err_timeout) tout_b++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [MW-1:0] d, input bit expect_rx);
    int n = 0;
    while (!a_tx_ready && n < 500) begin step(); n++; end
    check("push_ready", 32'(a_tx_ready), 1);
    a_tx_valid = 1'b1;
    a_tx_data  = d;
    if (expect_rx) sb.push_back(d);
    step();
    a_tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || a_bus_oe) && n < 3000) begin step(); n++; end
    check(tag, 32'(sb.size()), 0);
    repeat (3) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] m;
    ctrl_msg_t     f;
    int            n;

    a_transmit = 1'b1; b_transmit = 1'b0;
    a_tx_valid = 1'b0; b_tx_valid = 1'b0;
    a_tx_data  = '0;   b_tx_data  = '0;
    repeat (3) step();
    check("rst_tx_ready", 32'(a_tx_ready), 1);
    check("rst_req",      32'(a_req_out), 0);
    check("rst_oe",       32'(a_bus_oe), 0);
    check("rst_bus",      32'(a_bus_out), 0);
    check("rst_ack",      32'(b_ack_out), 0);
    check("rst_rx_valid", 32'(b_rx_valid), 0);
    check("rst_rx_data",  32'(b_rx_data), 0);
    rst = 1'b1;
    repeat (3) step();

    // Single message and first-beat latency
    m = 22'h2A5F3C;
    a_tx_valid = 1'b1; a_tx_data = m; sb.push_back(m);
    step();
    a_tx_valid = 1'b0;
    check("lat_oe",     32'(a_bus_oe), 1);
    check("lat_beat0",  32'(a_bus_out), 32'(m[DW-1:0]));
    check("lat_req_lo", 32'(a_req_out), 0);
    step();
    check("lat_req_hi", 32'(a_req_out), 1);
    wait_drain("single_drain");
    check("single_perr", 32'(perr_seen), 0);
    check("single_hold", 32'(b_rx_data), 32'(m));

    // Four back-to-back messages fill the FIFO
    f.move_dir = 1'b1; f.block_x = 5'd19; f.block_y = 3'd5;
    f.msg_type = 4'hA; f.card = 6'd33; f.sel_len = 3'd6;
    push(pack_ctrl(f), 1);
    push(22'h3FFFFF, 1);
    push(22'h000001, 1);
    push(MW'($urandom), 1);
    check("full_ready", 32'(a_tx_ready), 0);
    n = 0;
    while (!a_tx_ready && n < 1000) begin step(); n++; end
    check("pop_ready", 32'(a_tx_ready), 1);
    check("pop_order", 32'(sb.size()), 3);
    wait_drain("burst_drain");

    // Corrupt beat 2 of one message
    flip_en = 1'b1;
    m = last_good;
    push(22'h155AA3, 0);
    n = 0;
    while (perr_seen == 0 && n < 500) begin step(); n++; end
    check("perr_pulse", 32'(perr_seen), 1);
    check("perr_hold",  32'(b_rx_data), 32'(m));
    wait_drain("perr_drain");
    flip_en = 1'b0;
    push(22'h0ABCDE, 1);
    wait_drain("perr_recover");
    check("perr_once", 32'(perr_seen), 1);

    // Receiver disconnected: first message times out, second goes through
    disc = 1'b1;
    push(22'h111111, 0);
    push(22'h222222, 1);
    n = 0;
    while (!a_req_out && n < 20) begin step(); n++; end
    n = 0;
    while (!a_err_timeout && n < TO + 50) begin step(); n++; end
    check("to_window", 32'(n >= TO && n <= TO + 1), 1);
    check("to_req_lo", 32'(a_req_out), 0);
    disc = 1'b0;
    wait_drain("to_drain");
    check("to_count_a", 32'(tout_a), 1);
    check("to_count_b", 32'(tout_b), 0);

    // Asynchronous reset while A is releasing beat 1
    push(22'h3C3C3C, 0);
    n = 0;
    while (!(tb_beat == 2 && a_bus_oe && !a_req_out) && n < 200) begin step(); n++; end
    check("rst_at_rel", 32'(tb_beat), 2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req",   32'(a_req_out), 0);
    check("arst_oe",    32'(a_bus_oe), 0);
    check("arst_bus",   32'(a_bus_out), 0);
    check("arst_ready", 32'(a_tx_ready), 1);
    check("arst_ack",   32'(b_ack_out), 0);
    check("arst_rxd",   32'(b_rx_data), 0);
    check("arst_errt",  32'(a_err_timeout), 0);
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    push(22'h2468AC, 1);
    wait_drain("arst_recover");
    check("arst_no_to",   32'(tout_a + tout_b), 1);
    check("arst_no_perr", 32'(perr_seen), 1);

    // Role request flipped mid-transfer
    push(22'h13579B, 1);
    n = 0;
    while (tb_beat != 1 && n < 200) begin step(); n++; end
    a_transmit = 1'b0;
    b_transmit = 1'b1;
    repeat (4) step();
    check("role_hold_oe", 32'(a_bus_oe), 1);
    wait_drain("role_drain");
    a_transmit = 1'b1;
    b_transmit = 1'b0;
    repeat (3) step();
    push(22'h0F0F0F, 1);
    wait_drain("role_restore");
    check("final_perr", 32'(perr_seen), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/interboard_link.md
# interboard_link

Parametrised board-to-board message link that replaces the fixed-format interboard transceiver. It carries messages of MW bits over a DW-bit shared data bus using a four-phase Request/Ack handshake, with an even-parity bit, a TX message FIFO, two-flop synchronisers on the incoming handshake lines, and a handshake timeout. It sits between the game controller (ctrl_* fields packed into tx_data) and the board-level tristate pads, which live in the top level.

## Interface
- MW, 22: message width (move_dir 1 + block_x 5 + block_y 3 + msg_type 4 + card 6 + sel_len 3).
- DW, 6: interboard data bus width.
- FIFO_DEPTH, 4: TX message FIFO depth, power of two, ≥ 2.
- TIMEOUT, 1023: maximum cycles spent waiting for any single handshake edge.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- transmit  in  1  1 = this board drives the bus (TX role), 0 = RX role; sampled only while both FSMs are idle.
- tx_valid / tx_ready  in / out  1  message push handshake; tx_ready = FIFO not full.
- tx_data  in  MW  message to send.
- rx_valid  out  1  one-cycle pulse: good message received.
- rx_data  out  MW  last good message; held until the next one.
- err_parity / err_timeout  out  1  one-cycle error pulses.
- req_out / ack_out  out  1  handshake lines to the pads.
- req_in / ack_in  in  1  handshake lines from the pads (asynchronous).
- bus_out  out  DW  data to the pads; bus_oe  out  1  pad output enable.
- bus_in  in  DW  data from the pads.

## Operation
- Frame = {parity, tx_data}, parity = ^tx_data (even). BEATS = ceil((MW+1)/DW), zero-padded in the top beat; beat 0 = LSBs. Defaults: 4 beats.
- req_in, ack_in pass through 2-flop synchronisers (req_s, ack_s); bus_in is used raw but only sampled once req_s = 1.
- TX FSM (active when role = TX): T_IDLE → T_SETUP when the FIFO is non-empty: drive bus_out with the current beat, bus_oe = 1, req_out = 0, one cycle. T_SETUP → T_REQ: req_out = 1, wait for ack_s = 1. T_REQ → T_REL: req_out = 0, wait for ack_s = 0. T_REL → T_SETUP for the next beat, or pop the FIFO and return to T_IDLE after the last beat. bus_oe stays high from T_SETUP through T_REL.
- RX FSM (active when role = RX, bus_oe = 0): R_IDLE waits for req_s = 1, captures bus_in into beat slot k, then ack_out = 1 → R_WAIT. R_WAIT waits for req_s = 0, then ack_out = 0 and k+1 → R_IDLE. After the last beat, check parity: on a match, update rx_data and pulse rx_valid; on a mismatch, pulse err_parity and leave rx_data unchanged. k resets to 0 either way.
- Timeout: a wait counter clears on every state change. Reaching TIMEOUT in T_REQ, T_REL, R_WAIT, or R_IDLE with k ≠ 0 aborts the message: TX drops req_out, pops and discards the head message, and goes to T_IDLE. RX drops ack_out and resets k. Both pulse err_timeout. Plain R_IDLE with k = 0 never times out.
- FIFO: a push occurs when tx_valid && tx_ready. A push while full is refused because tx_ready is low. Push and pop in the same cycle are allowed when not full, and the count is unchanged.
- Role changes while the TX FIFO is non-empty are ignored until T_IDLE; queued messages wait while role = RX.

## Timing
- Reset values: req_out = 0, ack_out = 0, bus_oe = 0, bus_out = 0, tx_ready = 1, rx_valid = 0, rx_data = 0, both error outputs 0, FIFO empty, FSMs idle, k = 0.
- Reset during a transfer abandons the transfer immediately, with no error pulse.
- Push on an empty FIFO at cycle 0 → T_SETUP (bus driven) at cycle 1 → req_out high at cycle 2.
- bus_out is stable at least one cycle before req_out rises and until req_s has fallen at the receiver, so a raw sample of bus_in is safe.
- Per beat with two linked instances: about 10 cycles (2 synchroniser cycles per edge × 4 edges, plus setup and capture). rx_valid fires 1 cycle after the final falling req_s is seen.

## Structure
- Package interboard_pkg: message field offsets and widths, beat-count function, TX and RX state enums, and a pack/unpack function for the six ctrl fields.
- Sub-module interboard_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push/pop/full/empty ports. Synchronisers and FSMs stay inline.

## Test plan
- Two instances A (transmit = 1) and B (transmit = 0), cross-wired. A pushes 22'h2A5F3C → B pulses rx_valid once with rx_data = 22'h2A5F3C, and err_parity stays 0.
- A pushes 4 messages back-to-back → tx_ready falls after the 4th. B receives all 4 in order. tx_ready rises after the first pop.
- Flip bus_in bit 0 on beat 2 → B pulses err_parity, rx_data keeps its previous value, and the next clean message is received correctly.
- B disconnected (ack_in tied 0) → A pulses err_timeout after TIMEOUT cycles in T_REQ. req_out = 0, the message is discarded, and the next queued message starts.
- Pull rst low while A is in T_REL on beat 1 → all outputs go to reset values asynchronously. After release, a new message transfers cleanly.
- Toggle transmit during a transfer → the role is unchanged until the FSMs are idle, and the transfer completes intact.
